counter_control_unit: RTL



---
 rtl/counter_ctrl_pkg.sv | 21 ++
 rtl/counter_control_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter control unit
//
// Contents:
//   state_t     : FSM state encoding used by counter_control_unit
//   COUNT_LIMIT : number of values a run emits (0..COUNT_LIMIT-1). The comparison
//                 itself (A < 10) lives in the counter datapath; this constant only
//                 names that bound for readers and benches.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    INCR  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] COUNT_LIMIT = 8'd10;

endpackage

// File: rtl/counter_control_unit.sv
// rtl/counter_control_unit.sv - Moore FSM sequencing the 8-bit counter datapath
//
// On a start request in IDLE the unit clears the A register, then for every value
// the datapath reports as below ten it enables the output buffer for HOLD_CYCLES
// cycles and increments A. When A reaches ten it pulses done for one cycle.
//
// Parameters:
//   HOLD_CYCLES : cycles OutBufSel stays high per emitted value (1..255)
//   HOLD_W      : width of the hold counter
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a run (sampled only in IDLE)
//   abort     in   synchronous abort back to IDLE, no done pulse
//   pause     in   hold the run, honoured only in CHECK
//   loop_en   in   auto-restart request (optional feature only)
//   ALt10     in   datapath comparator, A < 10
//   AsrcSel   out  datapath mux select: 0 -> constant 0, 1 -> A+1
//   ALoad     out  datapath A-register load enable
//   OutBufSel out  datapath output-buffer enable
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse at the end of a run
//
// Optional feature (macro COUNTER_CTRL_AUTO_RESTART_EN): when defined, DONE moves
// straight to CLEAR while loop_en is high; otherwise loop_en is ignored.
module counter_control_unit #(
  parameter int HOLD_CYCLES = 1,
  parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic pause,
  input  logic loop_en,
  input  logic ALt10,
  output logic AsrcSel,
  output logic ALoad,
  output logic OutBufSel,
  output logic busy,
  output logic done
);
  import counter_ctrl_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;

`ifndef COUNTER_CTRL_AUTO_RESTART_EN
  // Port kept for a stable interface; nothing consumes it in this build.
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Cleared on the way into EMIT; saturates so a long EMIT can never wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == CHECK && state_nxt == EMIT) begin
      hold_cnt <= '0;
    end else if (state == EMIT && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = CHECK;
      CHECK: begin
        if (pause)      state_nxt = CHECK;
        else if (ALt10) state_nxt = EMIT;
        else            state_nxt = DONE;
      end
      EMIT: begin
        if (hold_cnt == HOLD_LAST) state_nxt = INCR;
      end
      INCR: state_nxt = CHECK;
      DONE: begin
`ifdef COUNTER_CTRL_AUTO_RESTART_EN
        state_nxt = loop_en ? CLEAR : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Outputs depend on the registered state only.
  always_comb begin
    AsrcSel   = 1'b0;
    ALoad     = 1'b0;
    OutBufSel = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE:  busy = 1'b0;
      CLEAR: ALoad = 1'b1;
      CHECK: ;
      EMIT:  OutBufSel = 1'b1;
      INCR: begin
        AsrcSel = 1'b1;
        ALoad   = 1'b1;
      end
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
